// File: rtl/bcd_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the BCD step controller.
package bcd_ctrl_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ST_W  = 3;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam logic [SEL_W-1:0] SEL_UNITS = 2'b01;
  localparam logic [SEL_W-1:0] SEL_TENS  = 2'b10;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_STEP   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_CLEAR  = 3'd4;

  // Bits needed for a counter spanning 0..n-1 (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bcd_step_ctrl_tick_div.sv
// Divider producing a registered one-cycle tick every DIV enabled cycles.
module tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  import bcd_ctrl_pkg::*;

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Counter is held at zero while disabled so re-enabling starts a full period.
  always_comb begin
    cnt_d = '0;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_d = en_i && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/bcd_step_ctrl.sv
// Sequencer for the BCD ripple counter: step/settle/check, tens digit,
// fault flag and two-digit display scan.
module bcd_step_ctrl #(
  parameter int unsigned RUN_DIV       = 50000000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SCAN_DIV      = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pulse_i,
  input  logic       mode_run_i,
  input  logic       clr_req_i,
  input  logic [3:0] units_i,
  output logic       step_o,
  output logic       cnt_clr_o,
  output logic [3:0] tens_o,
  output logic       carry_o,
  output logic       fault_o,
  output logic       busy_o,
  output logic [1:0] seg_sel_o,
  output logic [3:0] seg_digit_o
);
  import bcd_ctrl_pkg::*;

  localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              from_clr_q, from_clr_d;
  logic [BCD_W-1:0]  prev_q, prev_d;
  logic [BCD_W-1:0]  tens_q, tens_d;
  logic              fault_q, fault_d;
  logic              carry_q, carry_d;
  logic              step_q, step_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic              busy_q, busy_d;
  logic [SEL_W-1:0]  seg_sel_q, seg_sel_d;
  logic [BCD_W-1:0]  seg_digit_q, seg_digit_d;

  logic run_tick, scan_tick, req_c;

  tick_div #(.DIV(RUN_DIV)) u_run_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (mode_run_i),
    .tick_o (run_tick)
  );

  tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .tick_o (scan_tick)
  );

  assign req_c = mode_run_i ? run_tick : btn_pulse_i;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    from_clr_d = from_clr_q;
    prev_d     = prev_q;
    tens_d     = tens_q;
    fault_d    = fault_q;
    carry_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
        end else if (req_c) begin
          state_d = ST_STEP;
          prev_d  = units_i;
        end
      end
      ST_STEP: begin
        state_d    = ST_SETTLE;
        settle_d   = '0;
        from_clr_d = 1'b0;
      end
      ST_SETTLE: begin
        if (settle_q == SLAST) state_d = from_clr_q ? ST_IDLE : ST_CHECK;
        else                   settle_d = settle_q + SW'(1);
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (units_i > BCD_MAX) begin
          fault_d = 1'b1;
        end else if (prev_q == BCD_MAX && units_i == '0) begin
          carry_d = 1'b1;
          tens_d  = (tens_q == BCD_MAX) ? '0 : tens_q + BCD_W'(1);
        end
      end
      ST_CLEAR: begin
        state_d    = ST_SETTLE;
        settle_d   = '0;
        from_clr_d = 1'b1;
        tens_d     = '0;
        fault_d    = 1'b0;
        prev_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear request aborts whatever is in flight, including a pending CHECK result.
    if (clr_req_i) begin
      state_d = ST_CLEAR;
      if (state_q == ST_CHECK) begin
        carry_d = 1'b0;
        tens_d  = tens_q;
        fault_d = fault_q;
      end
    end

    step_d    = (state_d == ST_STEP);
    cnt_clr_d = (state_d == ST_CLEAR);
    busy_d    = (state_d != ST_IDLE);

    seg_sel_d = seg_sel_q;
    if (scan_tick) seg_sel_d = (seg_sel_q == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
    seg_digit_d = (seg_sel_d == SEL_UNITS) ? units_i : tens_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      from_clr_q  <= 1'b0;
      prev_q      <= '0;
      tens_q      <= '0;
      fault_q     <= 1'b0;
      carry_q     <= 1'b0;
      step_q      <= 1'b0;
      cnt_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      seg_sel_q   <= SEL_UNITS;
      seg_digit_q <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      from_clr_q  <= from_clr_d;
      prev_q      <= prev_d;
      tens_q      <= tens_d;
      fault_q     <= fault_d;
      carry_q     <= carry_d;
      step_q      <= step_d;
      cnt_clr_q   <= cnt_clr_d;
      busy_q      <= busy_d;
      seg_sel_q   <= seg_sel_d;
      seg_digit_q <= seg_digit_d;
    end
  end

  assign step_o      = step_q;
  assign cnt_clr_o   = cnt_clr_q;
  assign tens_o      = tens_q;
  assign carry_o     = carry_q;
  assign fault_o     = fault_q;
  assign busy_o      = busy_q;
  assign seg_sel_o   = seg_sel_q;
  assign seg_digit_o = seg_digit_q;

endmodule

// File: doc/bcd_step_ctrl.md
Name: bcd_step_ctrl

Overview:
Controller that sequences the 8421 BCD ripple-counter datapath (JK chain plus 7-seg decode).
- Issues single-cycle step pulses from the debounced button (manual) or an internal prescaler (run).
- Waits for the ripple chain to settle, then checks the returned units digit.
- Detects 9->0 wrap, keeps a tens digit, flags illegal codes, and time-multiplexes two digits to the segment decoder.
- Sits between debounce and the counter/decoder in the top level.

Parameters:
RUN_DIV, 50000000, clk cycles per auto-step in run mode (>=2)
SETTLE_CYCLES, 4, cycles waited after step before sampling units (>=1)
SCAN_DIV, 50000, clk cycles per display digit slot (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_pulse  in  1  debounced single-cycle button pulse
mode_run  in  1  level; 1 = auto-run, 0 = manual
clr_req  in  1  single-cycle clear request
units  in  4  BCD value fed back from the counter datapath
step  out  1  single-cycle clock/advance pulse to the counter
cnt_clr  out  1  single-cycle clear to the counter
tens  out  4  tens digit, 0..9
carry  out  1  single-cycle pulse on units 9->0
fault  out  1  sticky; units read >9 at check
busy  out  1  1 whenever state != IDLE
seg_sel  out  2  one-hot digit enable: 01 = units, 10 = tens
seg_digit  out  4  BCD value for the active digit

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; step=0, cnt_clr=0, carry=0, fault=0, tens=0, busy=0; seg_sel=01, seg_digit=0; prescaler=0, scan counter=0.
- States: IDLE, STEP, SETTLE, CHECK, CLEAR.
- IDLE:
  - clr_req -> CLEAR.
  - Otherwise, a request -> STEP and units is latched into prev_units.
  - A request is btn_pulse when mode_run=0, or a prescaler tick when mode_run=1. btn_pulse is ignored in run mode.
- STEP: step=1 for exactly this cycle -> SETTLE.
- SETTLE: stays exactly SETTLE_CYCLES cycles -> CHECK.
- CHECK (one cycle) -> IDLE. Results are visible in the next cycle:
  - units>9: fault<=1, tens unchanged, no carry.
  - prev_units==9 and units==0: carry=1 for one cycle; tens<=tens+1, with 9->0 wrap.
  - Otherwise no change.
- CLEAR:
  - cnt_clr=1 for this cycle; tens<=0, fault<=0, prev_units<=0.
  - Then runs SETTLE for SETTLE_CYCLES and returns to IDLE without a CHECK.
- Latency: request at cycle n (IDLE) -> step at n+1 -> SETTLE n+2..n+1+S -> CHECK n+2+S -> carry/tens/fault updated and IDLE at n+3+S.
  - A new request is accepted at n+3+S.
- Priority and boundary cases:
  - clr_req in any state other than CLEAR aborts the operation next cycle: -> CLEAR, no carry, no tens update.
  - clr_req while in CLEAR or its settle restarts the CLEAR sequence.
  - btn_pulse or prescaler ticks arriving while busy=1 are dropped, not queued.
  - clr_req and a request in the same IDLE cycle: clear wins.
- Prescaler:
  - Counts only while mode_run=1; held at 0 while mode_run=0.
  - Tick when count==RUN_DIV-1, then wraps to 0.
  - Run->manual->run restarts a full RUN_DIV period.
- Display scan:
  - Free-running; slot toggles every SCAN_DIV cycles.
  - seg_digit is registered from units (slot 01) or tens (slot 10), sampled at the start of each slot and refreshed each cycle.
  - Scan is unaffected by the FSM and by clr_req; only rst resets it.
- tens never leaves 0..9. fault is cleared only by CLEAR or rst.

Decomposition:
- Package bcd_ctrl_pkg: state enum; BCD_MAX=9; SEL_UNITS=2'b01, SEL_TENS=2'b10; a clog2-style width function for divider counters.
- Sub-module tick_div (parameter DIV; inputs clk, rst, en; output tick), instantiated for the run prescaler and the scan timer.
- FSM and tens logic stay in bcd_step_ctrl.

Test Plan:
- Manual step (SETTLE_CYCLES=4): units=3, btn_pulse at cycle 10 (bench model returns units=4) -> step high only at 11, busy 11..16, carry=0, tens=0, IDLE at 17.
- Wrap: tens=0, units=9, btn_pulse, model returns 0 -> carry one cycle at n+7, tens=1. Repeat with tens=9 -> tens=0, carry pulses.
- Run mode, RUN_DIV=8: mode_run=1 held -> step every 8 cycles; btn_pulse injected mid-run -> no extra step.
- Busy drop: second btn_pulse during SETTLE -> exactly one step pulse total.
- Clear mid-op: clr_req in SETTLE with tens=5 -> cnt_clr one cycle, tens=0, no carry, IDLE after 1+4 cycles, busy=1 throughout.
- Fault: model returns units=12 at CHECK -> fault=1, held through later steps until clr_req -> fault=0. Scan with SCAN_DIV=4 -> seg_sel alternates 01/10 every 4 cycles, seg_digit=units/tens accordingly.
